rca_seq_ctrl: RTL

- Sequencer that adds two wide operands using one external 4-bit ripple-carry adder slice (a[3:0], b[3:0], cin -> sum[3:0], c4).
- Each cycle it feeds one nibble, least significant first, and chains the carry through a register.
- It collects the result and returns it over a valid/ready output handshake.
- Sits between a requesting datapath and the shared rca instance; trades adder area for NIBBLES cycles of latency.

---
 rtl/rca_seq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: adds two NIBBLES*4-bit operands through one shared 4-bit ripple-carry slice, LSB nibble first.
// Latency: out_valid rises NIBBLES edges after accept. Defining RCA_SEQ_SUB_EN adds a sub port for a-b.
// Backpressure: the result is held in DONE until out_ready. in_ready stays low while busy.
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_c4
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx;
  logic            last;
  logic            sub_reg;
  logic            start_carry;
  logic [3:0]      a_nib, b_nib;

`ifdef RCA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign start_carry = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_reg <= sub;
    end
  end
`else
  assign start_carry = cin;
  assign sub_reg     = 1'b0;
`endif

  assign last      = (idx == IW'(NIBBLES - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign a_nib = a_reg[4*idx +: 4];
  assign b_nib = b_reg[4*idx +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_nib;
        add_b   = sub_reg ? ~b_nib : b_nib;
        add_cin = carry_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= start_carry;
            idx       <= '0;
            sum       <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= add_sum;
          carry_reg       <= add_c4;
          // idx parks on the top nibble so DONE needs no extra bookkeeping.
          if (last) begin
            cout <= add_c4;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
